trace_capture_ctrl: RTL and testbench

//  Sequences trace capture into the trace memory. Grants store permission to the

---
 rtl/trace_capture_ctrl_if.sv | 26 ++
 rtl/trace_capture_ctrl.sv | 121 ++++++++++++
 tb/tb_trace_capture_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_ctrl_if.sv
// rtl/trace_capture_ctrl_if.sv - deserializer store, host read and trace memory bus bundle
interface trace_capture_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic [DATA_W-1:0] DATA_I;
   logic              STORE_I;
   logic              STORE_PERM_O;
   logic              RD_REQ_I;
   logic [ADDR_W-1:0] RD_ADDR_I;
   logic              RD_GNT_O;
   logic              MEM_EN_O;
   logic              MEM_WE_O;
   logic [ADDR_W-1:0] MEM_ADDR_O;
   logic [DATA_W-1:0] MEM_WDATA_O;

   modport master (
      output DATA_I, STORE_I, RD_REQ_I, RD_ADDR_I,
      input  STORE_PERM_O, RD_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O
   );

   modport slave (
      input  DATA_I, STORE_I, RD_REQ_I, RD_ADDR_I,
      output STORE_PERM_O, RD_GNT_O, MEM_EN_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O
   );
endinterface

// File: rtl/trace_capture_ctrl.sv
// rtl/trace_capture_ctrl.sv - trace capture sequencer sharing a single-port ring memory with host readout
module trace_capture_ctrl #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK_I,
   input  logic              RST_NI,
   input  logic              ARM_I,
   input  logic [ADDR_W:0]   POST_CNT_I,
   input  logic              TRIGGER_I,
   trace_capture_ctrl_if.slave bus,
   output logic [1:0]        STATE_O,
   output logic [ADDR_W-1:0] WR_PTR_O,
   output logic [ADDR_W-1:0] TRIG_ADDR_O,
   output logic              WRAPPED_O,
   output logic              OVERRUN_O
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ARMED = 2'b01,
      S_TRIG  = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              accept, store_acc, rd_ok;
   logic              do_arm, do_trig;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_inc, trig_addr_q;
   logic [ADDR_W:0]   post_cnt_q, post_cnt_inc;
   logic              wrapped_q, overrun_q;

   // Writes and host reads are split by state, so the memory port never sees both.
   assign accept       = (state_q == S_ARMED) || (state_q == S_TRIG);
   assign store_acc    = bus.STORE_I & accept;
   assign rd_ok        = bus.RD_REQ_I & ~accept;
   assign wr_ptr_inc   = wr_ptr_q + ADDR_W'(1);
   assign post_cnt_inc = post_cnt_q + (ADDR_W+1)'(1);

   always_comb begin
      state_d = state_q;
      do_arm  = 1'b0;
      do_trig = 1'b0;
      if (!ARM_I) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
               do_arm  = 1'b1;
            end
            S_ARMED: begin
               if (TRIGGER_I) begin
                  do_trig = 1'b1;
                  state_d = (POST_CNT_I == '0) ? S_DONE : S_TRIG;
               end
            end
            S_TRIG: begin
               if (store_acc && (post_cnt_inc == POST_CNT_I)) state_d = S_DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         bus.STORE_PERM_O <= 1'b0;
         bus.RD_GNT_O     <= 1'b0;
         bus.MEM_EN_O     <= 1'b0;
         bus.MEM_WE_O     <= 1'b0;
         bus.MEM_ADDR_O   <= '0;
         bus.MEM_WDATA_O  <= '0;
         wr_ptr_q         <= '0;
         trig_addr_q      <= '0;
         post_cnt_q       <= '0;
         wrapped_q        <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         // Permission follows the next state, so the final post-trigger store closes it.
         bus.STORE_PERM_O <= (state_d == S_ARMED) || (state_d == S_TRIG);
         bus.RD_GNT_O     <= rd_ok;
         bus.MEM_EN_O     <= store_acc | rd_ok;
         bus.MEM_WE_O     <= store_acc;
         if (store_acc) begin
            bus.MEM_ADDR_O  <= wr_ptr_q;
            bus.MEM_WDATA_O <= bus.DATA_I;
            wr_ptr_q        <= wr_ptr_inc;
            if (wr_ptr_q == ADDR_W'(DEPTH-1)) wrapped_q <= 1'b1;
            if (state_q == S_TRIG) post_cnt_q <= post_cnt_inc;
         end else if (rd_ok) begin
            bus.MEM_ADDR_O <= bus.RD_ADDR_I;
         end
         if (do_arm) begin
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            overrun_q   <= 1'b0;
         end else if (bus.STORE_I && !accept) begin
            overrun_q <= 1'b1;
         end
         // A store in the trigger cycle still counts as pre-trigger data.
         if (do_trig) begin
            trig_addr_q <= store_acc ? wr_ptr_inc : wr_ptr_q;
            post_cnt_q  <= '0;
         end
      end
   end

   assign STATE_O     = state_q;
   assign WR_PTR_O    = wr_ptr_q;
   assign TRIG_ADDR_O = trig_addr_q;
   assign WRAPPED_O   = wrapped_q;
   assign OVERRUN_O   = overrun_q;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb/tb_trace_capture_ctrl.sv - self-checking bench for trace_capture_ctrl
module tb_trace_capture_ctrl;
   localparam int DW = 16;
   localparam int DEPTH = 8;
   localparam int AW = 3;
   localparam int S_IDLE = 0, S_ARMED = 1, S_TRIG = 2, S_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          trig = 1'b0;
   logic [AW:0]   post = '0;
   logic [1:0]    state_o;
   logic [AW-1:0] wr_ptr_o, trig_addr_o;
   logic          wrapped_o, overrun_o;

   int total = 0;
   int bad = 0;

   trace_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   trace_capture_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .CLK_I       (clk),
      .RST_NI      (rst_n),
      .ARM_I       (arm),
      .POST_CNT_I  (post),
      .TRIGGER_I   (trig),
      .bus         (bus),
      .STATE_O     (state_o),
      .WR_PTR_O    (wr_ptr_o),
      .TRIG_ADDR_O (trig_addr_o),
      .WRAPPED_O   (wrapped_o),
      .OVERRUN_O   (overrun_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: ring of DEPTH words, count of stores since trigger, four capture phases.
   int m_state, m_ptr, m_trig, m_after, m_addr, m_wdata;
   bit m_wrap, m_ovr, m_perm, m_en, m_we, m_gnt;

   always @(posedge clk or negedge rst_n) begin
      bit acc, st, rd;
      int nxt;
      if (!rst_n) begin
         m_state = S_IDLE; m_ptr = 0; m_trig = 0; m_after = 0; m_addr = 0; m_wdata = 0;
         m_wrap = 0; m_ovr = 0; m_perm = 0; m_en = 0; m_we = 0; m_gnt = 0;
      end else begin
         acc  = (m_state == S_ARMED) || (m_state == S_TRIG);
         st   = bus.STORE_I && acc;
         rd   = bus.RD_REQ_I && !acc;
         m_en = st || rd;
         m_we = st;
         m_gnt = rd;
         if (st) begin
            m_addr  = m_ptr;
            m_wdata = int'(bus.DATA_I);
         end else if (rd) begin
            m_addr = int'(bus.RD_ADDR_I);
         end
         if (bus.STORE_I && !acc) m_ovr = 1;
         if (st) begin
            if (m_ptr == DEPTH - 1) m_wrap = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
         end
         nxt = m_state;
         if (!arm) begin
            nxt = S_IDLE;
         end else if (m_state == S_IDLE) begin
            nxt = S_ARMED; m_ptr = 0; m_wrap = 0; m_ovr = 0; m_trig = 0;
         end else if (m_state == S_ARMED && trig) begin
            m_trig  = m_ptr;
            m_after = 0;
            nxt     = (post == 0) ? S_DONE : S_TRIG;
         end else if (m_state == S_TRIG && st) begin
            m_after++;
            if (m_after == int'(post)) nxt = S_DONE;
         end
         m_state = nxt;
         m_perm  = (nxt == S_ARMED) || (nxt == S_TRIG);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("state", int'(state_o), m_state);
         chk("wr_ptr", int'(wr_ptr_o), m_ptr);
         chk("trig_addr", int'(trig_addr_o), m_trig);
         chk("wrapped", int'(wrapped_o), int'(m_wrap));
         chk("overrun", int'(overrun_o), int'(m_ovr));
         chk("perm", int'(bus.STORE_PERM_O), int'(m_perm));
         chk("mem_en", int'(bus.MEM_EN_O), int'(m_en));
         chk("mem_we", int'(bus.MEM_WE_O), int'(m_we));
         chk("rd_gnt", int'(bus.RD_GNT_O), int'(m_gnt));
         if (m_en) chk("mem_addr", int'(bus.MEM_ADDR_O), m_addr);
         if (m_we) chk("mem_wdata", int'(bus.MEM_WDATA_O), m_wdata);
      end
   end

   task automatic cyc(input bit a, input bit t, input bit s, input int d, input bit r, input int ra);
      arm           = a;
      trig          = t;
      bus.STORE_I   = s;
      bus.DATA_I    = DW'(d);
      bus.RD_REQ_I  = r;
      bus.RD_ADDR_I = AW'(ra);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, int'(state_o), 0);
      chk({tag, "_wr_ptr"}, int'(wr_ptr_o), 0);
      chk({tag, "_trig_addr"}, int'(trig_addr_o), 0);
      chk({tag, "_wrapped"}, int'(wrapped_o), 0);
      chk({tag, "_overrun"}, int'(overrun_o), 0);
      chk({tag, "_perm"}, int'(bus.STORE_PERM_O), 0);
      chk({tag, "_mem_en"}, int'(bus.MEM_EN_O), 0);
      chk({tag, "_mem_we"}, int'(bus.MEM_WE_O), 0);
      chk({tag, "_rd_gnt"}, int'(bus.RD_GNT_O), 0);
      chk({tag, "_mem_addr"}, int'(bus.MEM_ADDR_O), 0);
   endtask

   initial begin
      bus.STORE_I = 1'b0; bus.DATA_I = '0; bus.RD_REQ_I = 1'b0; bus.RD_ADDR_I = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Asynchronous reset in the middle of a capture
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, i + 1, 0, 0);
      chk("pre_reset_wr_ptr", int'(wr_ptr_o), 5);
      #2 rst_n = 1'b0;
      arm = 1'b0; bus.STORE_I = 1'b0;
      #1 chk_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // POST_CNT=3: 4 pre-trigger stores, trigger, 3 post-trigger stores
      post = 4'd3;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 5);
      chk("armed_rd_gnt", int'(bus.RD_GNT_O), 0);
      chk("armed_rd_mem_en", int'(bus.MEM_EN_O), 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 'h100 + i, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("t2_trig_addr", int'(trig_addr_o), 4);
      chk("t2_state_trig", int'(state_o), S_TRIG);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 'h200 + i, 0, 0);
      chk("t2_state_done", int'(state_o), S_DONE);
      chk("t2_wr_ptr", int'(wr_ptr_o), 7);
      chk("t2_perm", int'(bus.STORE_PERM_O), 0);
      chk("t2_last_addr", int'(bus.MEM_ADDR_O), 6);
      chk("t2_last_wdata", int'(bus.MEM_WDATA_O), 'h202);
      cyc(1, 0, 1, 'h3AA, 0, 0);
      chk("done_store_mem_en", int'(bus.MEM_EN_O), 0);
      chk("done_store_overrun", int'(overrun_o), 1);
      cyc(1, 0, 0, 0, 1, 5);
      chk("done_rd_gnt", int'(bus.RD_GNT_O), 1);
      chk("done_rd_addr", int'(bus.MEM_ADDR_O), 5);
      chk("done_rd_we", int'(bus.MEM_WE_O), 0);
      chk("done_rd_en", int'(bus.MEM_EN_O), 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("disarm_state", int'(state_o), S_IDLE);
      chk("disarm_overrun_kept", int'(overrun_o), 1);
      chk("disarm_trig_kept", int'(trig_addr_o), 4);
      chk("disarm_ptr_kept", int'(wr_ptr_o), 7);

      // Ring wrap: 10 pre-trigger stores into 8 words
      post = 4'd2;
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 1, 'h300 + i, 0, 0);
         if (i == 6) chk("wrap_before", int'(wrapped_o), 0);
         if (i == 7) chk("wrap_after", int'(wrapped_o), 1);
      end
      chk("wrap_wr_ptr", int'(wr_ptr_o), 2);
      cyc(1, 1, 0, 0, 0, 0);
      chk("wrap_trig_addr", int'(trig_addr_o), 2);
      cyc(0, 0, 0, 0, 0, 0);
      chk("abort_state", int'(state_o), S_IDLE);
      chk("abort_wrap_kept", int'(wrapped_o), 1);

      // POST_CNT=0 with a store coinciding with the trigger
      post = 4'd0;
      cyc(1, 0, 0, 0, 0, 0);
      chk("rearm_wrap_clr", int'(wrapped_o), 0);
      cyc(1, 0, 1, 'h11, 0, 0);
      cyc(1, 1, 1, 'hBEEF, 0, 0);
      chk("p0_addr", int'(bus.MEM_ADDR_O), 1);
      chk("p0_wdata", int'(bus.MEM_WDATA_O), 'hBEEF);
      chk("p0_we", int'(bus.MEM_WE_O), 1);
      chk("p0_trig_addr", int'(trig_addr_o), 2);
      chk("p0_state", int'(state_o), S_DONE);
      chk("p0_perm", int'(bus.STORE_PERM_O), 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 'h55, 0, 0);
      chk("idle_store_overrun", int'(overrun_o), 1);
      chk("idle_store_mem_en", int'(bus.MEM_EN_O), 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
